pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic, parametrised pipeline stage register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries a data payload and a control payload between stages under a valid/ready handshake.
//   Supports stall (bubble insertion), flush (squash) and a saturating backpressure counter.
//   Control bits (RegWrite, MemWrite, ResultSrc...) are zeroed whenever the stage holds a bubble.
// PARAMETERS
//   DATA_W  136  data payload width (ALU result, read data, PC+4, imm, rd...)
//   CTRL_W  3    control payload width; forced to 0 on bubble/flush/reset
//   CNT_W   16   width of backpressure counter stall_cnt
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   flush      in   1       squash stage contents this cycle
//   stall      in   1       block input acceptance (hazard unit)
//   in_valid   in   1       upstream item present
//   in_ready   out  1       stage accepts item this cycle
//   in_data    in   DATA_W  upstream data payload
//   in_ctrl    in   CTRL_W  upstream control payload
//   out_valid  out  1       stage holds valid item
//   out_ready  in   1       downstream consumes item this cycle
//   out_data   out  DATA_W  registered data payload
//   out_ctrl   out  CTRL_W  registered control payload (0 when !out_valid)
//   stall_cnt  out  CNT_W   cycles with in_valid && !in_ready, saturating
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, skid cleared.
//   - in_fire = in_valid && in_ready; out_fire = out_valid && out_ready. Latency in->out 1 cycle.
//   - in_ready = !flush && !stall && (!out_valid || out_ready)  [no skid build].
//   - Priority per cycle: rst > flush > in_fire > out_fire.
//   - flush: out_valid<=0, out_ctrl<=0, out_data held; concurrent input dropped (in_ready=0).
//   - in_fire: out_data<=in_data, out_ctrl<=in_ctrl, out_valid<=1 (simultaneous out_fire = pass-through).
//   - out_fire without in_fire: out_valid<=0, out_ctrl<=0 (bubble); out_data held.
//   - stall: input blocked; held item still drains on out_ready, leaving a bubble.
//   - !out_ready with out_valid: all outputs held stable; never drop or duplicate an item.
//   - in_valid=0: no load regardless of in_data/in_ctrl values.
//   - stall_cnt: +1 each cycle in_valid && !in_ready (incl. flush/stall); saturates at 2^CNT_W-1.
// CONFIGURATION
//   PIPE_SKID_EN defined: adds one-entry skid buffer; in_ready = !flush && !stall && !skid_valid
//     (registered, no out_ready combinational path). in_fire while out held and !out_ready
//     -> item to skid. out_fire with skid_valid -> skid moves to output next cycle.
//     flush clears output and skid. FIFO order preserved; throughput 1/cycle.
//   PIPE_SKID_EN undefined: no skid; in_ready depends combinationally on out_ready (above).
// STRUCTURE
//   pipe_pkg: default DATA_W/CTRL_W/CNT_W constants, MEM/WB field offsets, ctrl_t typedef.
//   Sub-module pipe_skid_buf (one-entry skid) instantiated only under PIPE_SKID_EN.
//   Counter logic inline; no other sub-modules.
// TESTING
//   1 Reset: rst=1 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
//   2 Streaming: out_ready=1, in_valid=1, data 1..8 back-to-back -> out_data 1..8 one cycle later, no gaps.
//   3 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs held, stall_cnt=3 (no skid;
//     with skid, stall_cnt=2 and one item in skid), no loss/duplication after release.
//   4 Stall: stall=1 one cycle, out_ready=1, ctrl=3'b101 held -> next cycle out_valid=0, out_ctrl=0.
//   5 Flush with in_valid=1, data=0xAA -> out_valid=0 next cycle, 0xAA never appears at output.
//   6 Saturation: CNT_W=4, in_valid=1, stall=1 for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, MEM/WB payload layout and control-bundle type for the pipeline stage registers.
// Pure declarations: no latency, no flow control.
package pipe_pkg;

  localparam int DATA_W_DEF = 136;
  localparam int CTRL_W_DEF = 3;
  localparam int CNT_W_DEF  = 16;

  // MEM/WB data payload field offsets (LSB positions within the data word)
  localparam int WB_ALU_LSB   = 0;
  localparam int WB_RDATA_LSB = 32;
  localparam int WB_PC4_LSB   = 64;
  localparam int WB_IMM_LSB   = 96;
  localparam int WB_RD_LSB    = 128;
  localparam int WB_RD_W      = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic result_src;
  } ctrl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid store for pipe_stage_reg (only used when PIPE_SKID_EN is defined).
// Load/unload take effect next cycle; holds one item while the output register is blocked.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              skid_valid,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl
);

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (clr) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (load) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
    end else if (unload) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall, flush and saturating stall counter; PIPE_SKID_EN adds a skid entry.
// 1-cycle latency; in_ready drops on flush/stall/full output (skid build: registered, no out_ready path).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic              out_open;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign out_open    = !out_valid || out_ready;
  assign in_ready    = !flush && !stall && !skid_valid;
  // in_fire and skid_valid are exclusive, so skid never loads and unloads together
  assign skid_load   = in_fire && !out_open;
  assign skid_unload = out_fire && skid_valid;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .load       (skid_load),
    .unload     (skid_unload),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .skid_valid (skid_valid),
    .skid_data  (skid_data),
    .skid_ctrl  (skid_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (skid_unload) begin
      out_valid <= 1'b1;
      out_data  <= skid_data;
      out_ctrl  <= skid_ctrl;
    end else if (in_fire && out_open) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_ctrl  <= in_ctrl;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end
`else
  assign in_ready = !flush && !stall && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_ctrl  <= in_ctrl;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end
`endif

  // Counts every refused offer, including those refused by flush or stall
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg, compared against a queue-based stage model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 136;
  localparam int CW = 3;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, stall, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt;

  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [CW-1:0] out_ctrl4;
  logic [3:0]    stall_cnt4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4),
    .stall_cnt(stall_cnt4)
  );

  // Reference model: the stage is a FIFO of DEPTH items; out_data shows the head, else the last head
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  item_t         q[$];
  logic [DW-1:0] held;
  int            cnt16, cnt4;
  bit            armed = 1'b0;
  int            n_vec = 0;
  int            n_miss = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    if (flush || stall) return 1'b0;
    if (DEPTH == 1) return (q.size() == 0) || out_ready;
    return q.size() < DEPTH;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic step(input bit r, input bit f, input bit s, input bit iv, input bit orr,
                      input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit rdy, ofire;
    item_t it;
    @(negedge clk);
    if (armed) begin
      check("out_valid",  DW'(out_valid),  DW'(q.size() > 0));
      check("out_ctrl",   DW'(out_ctrl),   DW'((q.size() > 0) ? q[0].c : 3'd0));
      check("out_data",   out_data,        held);
      check("stall_cnt",  DW'(stall_cnt),  DW'(cnt16));
      check("out_valid4", DW'(out_valid4), DW'(q.size() > 0));
      check("stall_cnt4", DW'(stall_cnt4), DW'(cnt4));
    end
    rst = r; flush = f; stall = s; in_valid = iv; out_ready = orr;
    in_data = d; in_ctrl = c;
    #1;
    rdy = exp_ready();
    if (armed) check("in_ready", DW'(in_ready), DW'(rdy));
    @(posedge clk);
    if (r) begin
      q.delete();
      held = '0;
      cnt16 = 0;
      cnt4 = 0;
      armed = 1'b1;
    end else begin
      if (iv && !rdy) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (f) begin
        q.delete();
      end else begin
        ofire = (q.size() > 0) && orr;
        if (ofire) void'(q.pop_front());
        if (iv && rdy) begin
          it.d = d;
          it.c = c;
          q.push_back(it);
        end
        if (q.size() > 0) held = q[0].d;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;

    // Reset held for two cycles while upstream offers data
    repeat (2) step(1, 0, 0, 1, 1, rnd_data(), 3'b111);

    // Back-to-back streaming, data 1..8
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 1, DW'(i), 3'(i));

    // Downstream blocked for three cycles, then drained
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, DW'(32'h100 + i), 3'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, rnd_data(), 3'd0);

    // Stall while a ctrl=101 item drains
    step(0, 0, 0, 1, 0, DW'(32'h55), 3'b101);
    step(0, 0, 1, 1, 1, DW'(32'h66), 3'b101);
    step(0, 0, 0, 0, 0, '0, 3'd0);

    // Flush with a concurrent offer of 0xAA
    step(0, 0, 0, 1, 0, DW'(32'h77), 3'b011);
    step(0, 1, 0, 1, 1, DW'(32'hAA), 3'b110);
    step(0, 0, 0, 0, 1, '0, 3'd0);
    step(0, 0, 0, 0, 1, '0, 3'd0);

    // Counter saturation: narrow counter must stick at 15
    step(1, 0, 0, 0, 1, '0, 3'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 1, rnd_data(), 3'd7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), rnd_data(), 3'($urandom_range(0, 7)));
    end
    step(0, 0, 0, 0, 1, '0, 3'd0);
    step(0, 0, 0, 0, 1, '0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
